spi_request_arbiter: RTL and testbench

SPI_REQUEST_ARBITER -- requirements
Module: spi_request_arbiter

---
 rtl/spi_request_arbiter_pkg.sv | 25 ++
 rtl/spi_request_arbiter_rr_pick.sv | 26 ++
 rtl/spi_request_arbiter.sv | 157 +++++++++++++++
 tb/tb_spi_request_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_request_arbiter_pkg.sv
// spi_pkg: shared FSM states, slave-select codes and mode bit positions for spi_request_arbiter
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT_BUSY,
      XFER,
      GUARD
   } state_e;

   localparam logic [1:0] SS_NONE = 2'd0;
   localparam logic [1:0] SS_1    = 2'd1;
   localparam logic [1:0] SS_2    = 2'd2;
   localparam logic [1:0] SS_3    = 2'd3;

   localparam int MODE_CPHA = 0;
   localparam int MODE_CPOL = 1;

   function automatic logic [1:0] ss_of(input logic [1:0] idx);
      return (idx == 2'd0) ? SS_1 : (idx == 2'd1) ? SS_2 : SS_3;
   endfunction

endpackage

// File: rtl/spi_request_arbiter_rr_pick.sv
// rr_pick: combinational cyclic search for the first active request at or after ptr
module rr_pick #(
   parameter int N_REQ = 3
) (
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       ptr,
   output logic [1:0]       idx,
   output logic             valid
);

   // Walk the offsets from farthest to nearest so the nearest active request wins
   always_comb begin
      int j;
      j     = 0;
      idx   = 2'd0;
      valid = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N_REQ;
         if (req[j]) begin
            idx   = 2'(j);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_request_arbiter.sv
// spi_request_arbiter: round-robin arbiter sequencing one SPI transfer per grant; timeout option SPI_ARB_TIMEOUT_EN
module spi_request_arbiter
   import spi_pkg::*;
#(
   parameter int N_REQ       = 3,
   parameter int GUARD_CYC   = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] tx_data,
   input  logic [2*N_REQ-1:0] mode,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic [7:0]         rx_data,
   output logic               err,
   output logic               m_cpol,
   output logic               m_cpha,
   output logic [1:0]         m_ss,
   output logic               m_load,
   output logic [7:0]         m_data,
   output logic               m_start,
   input  logic [7:0]         m_rx,
   input  logic               m_busy
);

   localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

   state_e           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d, win_q, win_d, mode_q, mode_d, m_ss_q, m_ss_d;
   logic [GW-1:0]    gcnt_q, gcnt_d;
   logic [7:0]       data_q, data_d, rx_q, rx_d, m_data_q, m_data_d;
   logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
   logic             err_q, err_d, m_load_q, m_load_d, m_start_q, m_start_d;
   logic             m_cpol_q, m_cpol_d, m_cpha_q, m_cpha_d;
   logic             busy_s1_q, busy_s1_d, busy_s2_q, busy_s2_d;
   logic [1:0]       pick_idx;
   logic             pick_vld, grab, fin, act, busy_phase, tmo_hit;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   assign busy_phase = (state_q == WAIT_BUSY) || (state_q == XFER);
   assign grab       = (state_q == IDLE) && pick_vld;
   assign fin        = busy_phase && (state_d == GUARD);
   assign act        = (state_d == LOAD) || (state_d == START) || (state_d == WAIT_BUSY) || (state_d == XFER);

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tcnt_q, tcnt_d;
   // Timeout counter runs only while waiting on the SPI master
   always_comb tcnt_d = busy_phase ? tcnt_q + TW'(1) : '0;
   // Timeout counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tcnt_q <= '0;
      else        tcnt_q <= tcnt_d;
   end
   assign tmo_hit = busy_phase && (tcnt_q == TW'(TIMEOUT_CYC - 1));
`else
   assign tmo_hit = busy_phase && (TIMEOUT_CYC < 1);
`endif

   // State and output registers, all cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         win_q     <= '0;
         gcnt_q    <= '0;
         data_q    <= '0;
         mode_q    <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         err_q     <= 1'b0;
         rx_q      <= '0;
         m_ss_q    <= SS_NONE;
         m_cpol_q  <= 1'b0;
         m_cpha_q  <= 1'b0;
         m_load_q  <= 1'b0;
         m_data_q  <= '0;
         m_start_q <= 1'b0;
         busy_s1_q <= 1'b0;
         busy_s2_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         win_q     <= win_d;
         gcnt_q    <= gcnt_d;
         data_q    <= data_d;
         mode_q    <= mode_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rx_q      <= rx_d;
         m_ss_q    <= m_ss_d;
         m_cpol_q  <= m_cpol_d;
         m_cpha_q  <= m_cpha_d;
         m_load_q  <= m_load_d;
         m_data_q  <= m_data_d;
         m_start_q <= m_start_d;
         busy_s1_q <= busy_s1_d;
         busy_s2_q <= busy_s2_d;
      end
   end

   // Next-state logic; a timeout overrides the normal busy handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      state_d = pick_vld ? LOAD : IDLE;
         LOAD:      state_d = START;
         START:     state_d = WAIT_BUSY;
         WAIT_BUSY: state_d = (tmo_hit || !busy_s2_q) ? (tmo_hit ? GUARD : WAIT_BUSY) : XFER;
         XFER:      state_d = (tmo_hit || !busy_s2_q) ? GUARD : XFER;
         GUARD:     state_d = (gcnt_q == GW'(GUARD_CYC - 1)) ? IDLE : GUARD;
         default:   state_d = IDLE;
      endcase
   end

   // Registered outputs; strobes trail their state by one cycle so START lands two cycles after GNT
   always_comb begin
      win_d     = grab ? pick_idx : win_q;
      data_d    = grab ? tx_data[8*pick_idx +: 8] : data_q;
      mode_d    = grab ? mode[2*pick_idx +: 2] : mode_q;
      gnt_d     = grab ? N_REQ'(1) << pick_idx : fin ? '0 : gnt_q;
      done_d    = fin ? N_REQ'(1) << win_q : '0;
      err_d     = fin && tmo_hit;
      rx_d      = fin ? (tmo_hit ? 8'h00 : m_rx) : rx_q;
      gcnt_d    = (state_q == GUARD) ? gcnt_q + GW'(1) : '0;
      ptr_d     = (state_q == GUARD && state_d == IDLE) ? ((win_q == 2'(N_REQ - 1)) ? 2'd0 : win_q + 2'd1) : ptr_q;
      m_ss_d    = act ? ss_of(win_d) : SS_NONE;
      m_cpol_d  = act && mode_d[MODE_CPOL];
      m_cpha_d  = act && mode_d[MODE_CPHA];
      m_load_d  = (state_q == LOAD);
      m_data_d  = (state_q == LOAD) ? data_q : 8'h00;
      m_start_d = (state_q == START);
      busy_s1_d = m_busy;
      busy_s2_d = busy_s1_q;
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign err     = err_q;
   assign rx_data = rx_q;
   assign m_ss    = m_ss_q;
   assign m_cpol  = m_cpol_q;
   assign m_cpha  = m_cpha_q;
   assign m_load  = m_load_q;
   assign m_data  = m_data_q;
   assign m_start = m_start_q;

endmodule

// File: tb/tb_spi_request_arbiter.sv
// tb_spi_request_arbiter: table-driven transactions plus timeout and mid-transfer reset sequences
module tb_spi_request_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  req = '0;
   logic [23:0] tx_data = '0;
   logic [5:0]  mode = '0;
   logic [2:0]  gnt, done;
   logic [7:0]  rx_data, m_data;
   logic        err, m_cpol, m_cpha, m_load, m_start;
   logic [1:0]  m_ss;
   logic [7:0]  m_rx = '0;
   logic        m_busy = 1'b0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   spi_request_arbiter dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .tx_data (tx_data),
      .mode    (mode),
      .gnt     (gnt),
      .done    (done),
      .rx_data (rx_data),
      .err     (err),
      .m_cpol  (m_cpol),
      .m_cpha  (m_cpha),
      .m_ss    (m_ss),
      .m_load  (m_load),
      .m_data  (m_data),
      .m_start (m_start),
      .m_rx    (m_rx),
      .m_busy  (m_busy)
   );

   typedef struct {
      logic [2:0]  req;
      logic [23:0] txd;
      logic [5:0]  mode;
      int          busy;
      logic [7:0]  rx;
      int          idx;
      int          lat;
      int          gap;
      bit          drop;
   } vec_t;

   vec_t tv[9];
   vec_t r1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run(input vec_t v);
      int n;
      logic [2:0] eg;
      eg = 3'b001 << v.idx;
      repeat (v.gap) begin
         req = '0;
         @(negedge clk);
      end
      req = v.req; tx_data = v.txd; mode = v.mode; m_busy = 1'b0; m_rx = 8'h00;
      n = 0;
      while (n == 0 || (gnt == '0 && n < 20)) begin
         @(negedge clk);
         n++;
      end
      chk("grant_latency", 32'(n), 32'(v.lat));
      chk("gnt", 32'(gnt), 32'(eg));
      chk("ss_at_grant", 32'(m_ss), 32'(v.idx + 1));
      chk("cpol_at_grant", 32'(m_cpol), 32'(v.mode[2*v.idx+1]));
      chk("cpha_at_grant", 32'(m_cpha), 32'(v.mode[2*v.idx]));
      if (v.drop) req = '0;
      tx_data = ~v.txd;
      mode = ~v.mode;
      @(negedge clk);
      chk("m_load", 32'(m_load), 32'd1);
      chk("m_data", 32'(m_data), 32'(v.txd[8*v.idx +: 8]));
      chk("no_start_in_load", 32'(m_start), 32'd0);
      @(negedge clk);
      chk("m_start", 32'(m_start), 32'd1);
      chk("load_one_cycle", 32'(m_load), 32'd0);
      m_busy = 1'b1;
      m_rx = v.rx;
      repeat (v.busy) @(negedge clk);
      chk("ss_mid", 32'(m_ss), 32'(v.idx + 1));
      chk("cpol_mid", 32'(m_cpol), 32'(v.mode[2*v.idx+1]));
      chk("gnt_mid", 32'(gnt), 32'(eg));
      m_busy = 1'b0;
      n = 0;
      while (n == 0 || (done == '0 && n < 10)) begin
         @(negedge clk);
         n++;
      end
      chk("done", 32'(done), 32'(eg));
      chk("rx_data", 32'(rx_data), 32'(v.rx));
      chk("err_clear", 32'(err), 32'd0);
      chk("gnt_released", 32'(gnt), 32'd0);
      chk("ss_guard", 32'({m_ss, m_cpol, m_cpha}), 32'd0);
      m_rx = 8'hEE;
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("rx_hold", 32'(rx_data), 32'(v.rx));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      bit hit;
      tv[0] = '{3'b111, 24'h332211, 6'b000000, 16, 8'h81, 0, 1, 2, 1'b0};
      tv[1] = '{3'b111, 24'h665544, 6'b000100,  4, 8'h42, 1, 2, 0, 1'b0};
      tv[2] = '{3'b111, 24'h998877, 6'b100000,  3, 8'hC3, 2, 2, 0, 1'b0};
      tv[3] = '{3'b111, 24'hCCBBAA, 6'b000011,  2, 8'h24, 0, 2, 0, 1'b0};
      tv[4] = '{3'b001, 24'h0000A5, 6'b000000, 16, 8'h3C, 0, 1, 3, 1'b1};
      tv[5] = '{3'b100, 24'h7E0000, 6'b110000,  8, 8'h99, 2, 1, 3, 1'b1};
      tv[6] = '{3'b011, 24'h00D2D1, 6'b001001,  5, 8'h11, 0, 1, 3, 1'b1};
      tv[7] = '{3'b110, 24'hE3E200, 6'b011000,  6, 8'h22, 1, 2, 0, 1'b0};
      tv[8] = '{3'b101, 24'hF300F1, 6'b100001,  3, 8'h33, 2, 2, 0, 1'b0};
      r1    = '{3'b010, 24'h005C00, 6'b000000,  3, 8'h77, 1, 1, 3, 1'b1};

      repeat (2) @(negedge clk);
      chk("reset_ctrl", 32'({gnt, done, err, m_load, m_start, m_ss, m_cpol, m_cpha}), 32'd0);
      chk("reset_data", 32'({m_data, rx_data}), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run(tv[i]);

      repeat (3) begin
         req = '0;
         @(negedge clk);
      end
      req = 3'b001; tx_data = 24'h0000C7; mode = '0; m_busy = 1'b0; m_rx = 8'h5E;
      n = 0;
      while (n == 0 || (gnt == '0 && n < 20)) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_gnt", 32'(gnt), 32'd1);
      req = '0;
      repeat (2) @(negedge clk);
      chk("tmo_start", 32'(m_start), 32'd1);
      n = 0;
`ifdef SPI_ARB_TIMEOUT_EN
      while (err == 1'b0 && done == '0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_cycles", 32'(n), 32'd64);
      chk("tmo_err", 32'(err), 32'd1);
      chk("tmo_done", 32'(done), 32'd1);
      chk("tmo_rx_zero", 32'(rx_data), 32'd0);
      @(negedge clk);
      chk("tmo_err_pulse", 32'({err, done}), 32'd0);
`else
      hit = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (err || done != '0) hit = 1'b1;
      end
      chk("no_tmo_pulse", 32'(hit), 32'd0);
      chk("stuck_gnt", 32'(gnt), 32'd1);
      chk("stuck_ss", 32'(m_ss), 32'd1);
`endif

      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run(r1);

      repeat (3) begin
         req = '0;
         @(negedge clk);
      end
      req = 3'b100; tx_data = 24'hAB0000; mode = 6'b110000; m_rx = 8'h6D;
      n = 0;
      while (n == 0 || (gnt == '0 && n < 20)) begin
         @(negedge clk);
         n++;
      end
      chk("mx_gnt", 32'(gnt), 32'd4);
      repeat (2) @(negedge clk);
      m_busy = 1'b1;
      repeat (6) @(negedge clk);
      chk("mx_active", 32'({m_ss, m_cpol, m_cpha}), 32'b1111);
      #2 rst_n = 1'b0;
      #1;
      chk("mx_reset_ctrl", 32'({gnt, done, err, m_load, m_start, m_ss, m_cpol, m_cpha}), 32'd0);
      chk("mx_reset_data", 32'({m_data, rx_data}), 32'd0);
      m_busy = 1'b0;
      req = 3'b110;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_gnt", 32'(gnt), 32'd2);
      chk("post_reset_ss", 32'(m_ss), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
